// File: rtl/fusion_seq_pkg.sv
// Shared types, legal operand widths and default sizes for the fusion-unit sequencer.
package fusion_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [3:0] WIDTH_1 = 4'd1;
    localparam logic [3:0] WIDTH_2 = 4'd2;
    localparam logic [3:0] WIDTH_4 = 4'd4;
    localparam logic [3:0] WIDTH_8 = 4'd8;

    localparam int DEFAULT_ACC_W = 32;
    localparam int DEFAULT_LEN_W = 8;

    function automatic logic is_legal_width(input logic [3:0] w);
        return (w == WIDTH_1) || (w == WIDTH_2) || (w == WIDTH_4) || (w == WIDTH_8);
    endfunction

endpackage

// File: rtl/fusion_seq_acc.sv
// Psum register stage plus sign/zero-extending accumulator for the fusion sequencer.
// FUSION_SEQ_ACC_SAT_EN switches wrap-around accumulation to saturating with a sticky acc_sat flag.
module fusion_seq_acc
    import fusion_seq_pkg::*;
#(
    parameter int ACC_W = DEFAULT_ACC_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             stage_valid,
    input  logic             signed_mode,
    input  logic [15:0]      psum,
    output logic [ACC_W-1:0] acc,
    output logic             pipe_valid
`ifdef FUSION_SEQ_ACC_SAT_EN
    ,
    output logic             acc_sat
`endif
);

    logic [15:0]      psum_reg;
    logic             pipe_valid_reg;
    logic [ACC_W-1:0] acc_reg;
    logic [ACC_W-1:0] acc_next;
    logic [ACC_W-1:0] psum_ext;

    assign psum_ext = signed_mode ? ACC_W'($signed(psum_reg)) : ACC_W'(psum_reg);

`ifdef FUSION_SEQ_ACC_SAT_EN
    logic [ACC_W:0] sum_u;
    logic [ACC_W:0] sum_s;
    logic           sat_hit;
    logic           acc_sat_reg;

    // One extra bit catches unsigned carry-out and signed overflow alike.
    always_comb begin
        sum_u    = {1'b0, acc_reg} + {1'b0, psum_ext};
        sum_s    = {acc_reg[ACC_W-1], acc_reg} + {psum_ext[ACC_W-1], psum_ext};
        acc_next = sum_u[ACC_W-1:0];
        sat_hit  = 1'b0;
        if (signed_mode) begin
            if (sum_s[ACC_W] != sum_s[ACC_W-1]) begin
                sat_hit  = 1'b1;
                acc_next = sum_s[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
            end
        end else if (sum_u[ACC_W]) begin
            sat_hit  = 1'b1;
            acc_next = '1;
        end
    end

    assign acc_sat = acc_sat_reg;
`else
    assign acc_next = acc_reg + psum_ext;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            psum_reg       <= '0;
            pipe_valid_reg <= 1'b0;
            acc_reg        <= '0;
`ifdef FUSION_SEQ_ACC_SAT_EN
            acc_sat_reg    <= 1'b0;
`endif
        end else if (clear) begin
            pipe_valid_reg <= 1'b0;
            acc_reg        <= '0;
`ifdef FUSION_SEQ_ACC_SAT_EN
            acc_sat_reg    <= 1'b0;
`endif
        end else begin
            pipe_valid_reg <= stage_valid;
            if (stage_valid) begin
                psum_reg <= psum;
            end
            if (pipe_valid_reg) begin
                acc_reg <= acc_next;
`ifdef FUSION_SEQ_ACC_SAT_EN
                acc_sat_reg <= acc_sat_reg | sat_hit;
`endif
            end
        end
    end

    assign acc        = acc_reg;
    assign pipe_valid = pipe_valid_reg;

endmodule

// File: rtl/fusion_seq_ctrl.sv
// Job sequencer for one fusion unit: config latch, operand input stage, result handshake.
// FUSION_SEQ_ACC_SAT_EN enables saturating accumulation and the acc_sat output.
module fusion_seq_ctrl
    import fusion_seq_pkg::*;
#(
    parameter int LEN_W = DEFAULT_LEN_W,
    parameter int ACC_W = DEFAULT_ACC_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       cfg_in_width,
    input  logic [3:0]       cfg_weight_width,
    input  logic             cfg_s_in,
    input  logic             cfg_s_weight,
    input  logic [LEN_W-1:0] cfg_len,
    output logic             cfg_err,
    output logic             busy,
    input  logic             op_valid,
    output logic             op_ready,
    input  logic [7:0]       op_in,
    input  logic [7:0]       op_weight,
    output logic [7:0]       fu_in,
    output logic [7:0]       fu_weight,
    output logic [3:0]       fu_in_width,
    output logic [3:0]       fu_weight_width,
    output logic             fu_s_in,
    output logic             fu_s_weight,
    input  logic [15:0]      fu_psum,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [ACC_W-1:0] res_data
`ifdef FUSION_SEQ_ACC_SAT_EN
    ,
    output logic             acc_sat
`endif
);

    state_t           state_reg;
    logic [LEN_W-1:0] remaining_reg;
    logic             cfg_err_reg;
    logic             busy_reg;
    logic             op_ready_reg;
    logic             res_valid_reg;
    logic             s0_valid_reg;
    logic [7:0]       fu_in_reg;
    logic [7:0]       fu_weight_reg;
    logic [3:0]       fu_in_width_reg;
    logic [3:0]       fu_weight_width_reg;
    logic             fu_s_in_reg;
    logic             fu_s_weight_reg;
    logic             start_ok;
    logic             accept;
    logic             s1_valid;

    assign start_ok = (state_reg == ST_IDLE) && start
                      && is_legal_width(cfg_in_width) && is_legal_width(cfg_weight_width);
    assign accept   = op_valid && op_ready_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg           <= ST_IDLE;
            remaining_reg       <= '0;
            cfg_err_reg         <= 1'b0;
            busy_reg            <= 1'b0;
            op_ready_reg        <= 1'b0;
            res_valid_reg       <= 1'b0;
            s0_valid_reg        <= 1'b0;
            fu_in_reg           <= '0;
            fu_weight_reg       <= '0;
            fu_in_width_reg     <= '0;
            fu_weight_width_reg <= '0;
            fu_s_in_reg         <= 1'b0;
            fu_s_weight_reg     <= 1'b0;
        end else begin
            cfg_err_reg  <= 1'b0;
            s0_valid_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (start_ok) begin
                        fu_in_width_reg     <= cfg_in_width;
                        fu_weight_width_reg <= cfg_weight_width;
                        fu_s_in_reg         <= cfg_s_in;
                        fu_s_weight_reg     <= cfg_s_weight;
                        remaining_reg       <= cfg_len;
                        busy_reg            <= 1'b1;
                        if (cfg_len == '0) begin
                            state_reg <= ST_DRAIN;
                        end else begin
                            state_reg    <= ST_RUN;
                            op_ready_reg <= 1'b1;
                        end
                    end else if (start) begin
                        cfg_err_reg <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (accept) begin
                        fu_in_reg     <= op_in;
                        fu_weight_reg <= op_weight;
                        s0_valid_reg  <= 1'b1;
                        remaining_reg <= remaining_reg - 1'b1;
                        if (remaining_reg == LEN_W'(1)) begin
                            state_reg    <= ST_DRAIN;
                            op_ready_reg <= 1'b0;
                        end
                    end
                end
                ST_DRAIN: begin
                    // With stage 0 empty, the pair in stage 1 lands in the accumulator on this edge.
                    if (!s0_valid_reg) begin
                        state_reg     <= ST_DONE;
                        res_valid_reg <= 1'b1;
                    end
                end
                ST_DONE: begin
                    if (res_ready) begin
                        state_reg     <= ST_IDLE;
                        res_valid_reg <= 1'b0;
                        busy_reg      <= 1'b0;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    fusion_seq_acc #(
        .ACC_W(ACC_W)
    ) u_acc (
        .clk        (clk),
        .rst        (rst),
        .clear      (start_ok),
        .stage_valid(s0_valid_reg),
        .signed_mode(fu_s_in_reg | fu_s_weight_reg),
        .psum       (fu_psum),
        .acc        (res_data),
        .pipe_valid (s1_valid)
`ifdef FUSION_SEQ_ACC_SAT_EN
        ,
        .acc_sat    (acc_sat)
`endif
    );

    assign cfg_err         = cfg_err_reg;
    assign busy            = busy_reg;
    assign op_ready        = op_ready_reg;
    assign res_valid       = res_valid_reg;
    assign fu_in           = fu_in_reg;
    assign fu_weight       = fu_weight_reg;
    assign fu_in_width     = fu_in_width_reg;
    assign fu_weight_width = fu_weight_width_reg;
    assign fu_s_in         = fu_s_in_reg;
    assign fu_s_weight     = fu_s_weight_reg;

endmodule
